div_result_unit: RTL
====================

DIV_RESULT_UNIT -- requirements
Module: div_result_unit

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 40, meaning the maximum number of WAIT cycles before a timeout.
REQ-002 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous active-low reset.
REQ-003 SHALL have ports: start input 1 CPU div issue; a_sign input 1 dividend MSB; m_sign input 1 divisor MSB; m_zero input 1 divisor equals zero.
REQ-004 SHALL have ports: div_start output 1 one-cycle launch to the unsigned divider; div_valid input 1 divider done; div_quo input 32 quotient magnitude; div_rem input 32 remainder magnitude.
REQ-005 SHALL have ports: HIin input 1; LOin input 1; bus_in input 32 register write bus; HIout input 1; LOout input 1.
REQ-006 SHALL have ports: HI output 32; LO output 32; bus_out output 32; busy output 1; dbz output 1 sticky divide-by-zero flag; tmo output 1 sticky timeout flag.

Function
REQ-007 SHALL implement FSM states IDLE, LAUNCH, WAIT, FIXUP, WRITE.
REQ-008 IDLE with start=1 and m_zero=0: SHALL latch a_sign and m_sign, then go to LAUNCH.
REQ-009 IDLE with start=1 and m_zero=1: SHALL go directly to WRITE with LO=32'hFFFFFFFF and HI=0, set dbz, and not assert div_start.
REQ-010 LAUNCH SHALL assert div_start for exactly one cycle, clear the watchdog counter, and go to WAIT.
REQ-011 WAIT SHALL stay until div_valid=1, then capture div_quo and div_rem and go to FIXUP.
REQ-012 WAIT SHALL increment the watchdog counter each cycle; when the count reaches WDOG_LIMIT without div_valid, it SHALL set tmo, leave HI/LO unchanged, and go to IDLE.
REQ-013 FIXUP SHALL negate the quotient (two's complement) when a_sign XOR m_sign, and negate the remainder when a_sign; it SHALL then go to WRITE.
REQ-014 WRITE SHALL load HI with the corrected remainder and LO with the corrected quotient, then go to IDLE.
REQ-015 Latency: div_valid sampled at edge k SHALL make HI/LO visible after edge k+2, with busy low after edge k+2.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 start while busy SHALL be ignored.
REQ-018 div_valid outside WAIT SHALL be ignored.
REQ-019 HIin/LOin SHALL load HI/LO from bus_in only in IDLE; they SHALL be ignored while busy.
REQ-020 bus_out SHALL be combinational: HI when HIout=1 (priority), else LO when LOout=1, else 0.
REQ-021 dbz and tmo SHALL clear on the next accepted start.
REQ-022 A quotient magnitude of 32'h80000000 SHALL negate to itself (wrap-around accepted, no flag).

Reset
REQ-023 reset low SHALL asynchronously force IDLE, and set HI=0, LO=0, div_start=0, busy=0, dbz=0, tmo=0, and the watchdog counter and latched signs to 0.
REQ-024 reset asserted mid-operation (any state) SHALL abandon the division; a later div_valid SHALL be ignored.

Structure
REQ-025 A shared package div_pkg SHALL hold the FSM state type, the default WDOG_LIMIT, and the divide-by-zero LO/HI constants.
REQ-026 One sub-module, div_sign_fix, SHALL hold the combinational conditional two's-complement negate, instantiated twice (quotient and remainder).

Verification
REQ-027 Case 7/2: start with a_sign=0, m_sign=0; div_quo=3, div_rem=1 -> LO=3, HI=1, div_start pulsed once.
REQ-028 Case -7/2: a_sign=1, m_sign=0; div_quo=3, div_rem=1 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-029 Case 7/-2: a_sign=0, m_sign=1; div_quo=3, div_rem=1 -> LO=32'hFFFFFFFD, HI=1.
REQ-030 Case m_zero=1 at start -> no div_start, LO=32'hFFFFFFFF, HI=0, dbz=1; next valid start clears dbz.
REQ-031 Case no div_valid for 40 WAIT cycles -> tmo=1, busy=0, HI/LO unchanged; a late div_valid has no effect.
REQ-032 Case reset low in WAIT, then div_valid -> IDLE, HI=LO=0; HIout=1 -> bus_out=0; HIin with bus_in=5 in IDLE -> HI=5.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the signed division result unit.
// No logic here: FSM state encoding, watchdog default, divide-by-zero results.
// Imported by div_result_unit and div_sign_fix.
package div_pkg;

  // Data width of the divider operands and the HI/LO registers
  localparam int DIV_W = 32;

  // Default number of WAIT cycles tolerated before declaring the divider hung
  localparam int DIV_WDOG_LIMIT = 40;

  // Results written on a divide-by-zero issue: all-ones quotient, zero remainder
  localparam logic [DIV_W-1:0] DBZ_LO = 32'hFFFF_FFFF;
  localparam logic [DIV_W-1:0] DBZ_HI = 32'h0000_0000;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FIXUP  = 3'd3,
    WRITE  = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate of an unsigned magnitude.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  logic [W-1:0] w_neg_val;

  // Most-negative value wraps to itself, which is the accepted behaviour
  assign w_neg_val = ~i_val + W'(1);
  assign o_val     = i_neg ? w_neg_val : i_val;

endmodule

// File: rtl/div_result_unit.sv
// Sequences an unsigned divider and applies sign correction into HI/LO.
// Latency: div_valid seen at edge k -> HI/LO updated and busy low after edge k+2.
// Backpressure: start and HIin/LOin are ignored while busy; watchdog aborts a hung divider.
module div_result_unit
  import div_pkg::*;
#(
  parameter int WDOG_LIMIT = DIV_WDOG_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a_sign,
  input  logic             m_sign,
  input  logic             m_zero,
  output logic             div_start,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_quo,
  input  logic [DIV_W-1:0] div_rem,
  input  logic             HIin,
  input  logic             LOin,
  input  logic [DIV_W-1:0] bus_in,
  input  logic             HIout,
  input  logic             LOout,
  output logic [DIV_W-1:0] HI,
  output logic [DIV_W-1:0] LO,
  output logic [DIV_W-1:0] bus_out,
  output logic             busy,
  output logic             dbz,
  output logic             tmo
);

  localparam int WDW = $clog2(WDOG_LIMIT + 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;

  logic             r_a_sign;
  logic             r_m_sign;
  logic             r_dbz;
  logic             r_tmo;
  logic [WDW-1:0]   r_wdog;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_hi;
  logic [DIV_W-1:0] r_lo;

  logic             w_accept;
  logic             w_wdog_done;
  logic             w_quo_neg;
  logic [DIV_W-1:0] w_quo_fix;
  logic [DIV_W-1:0] w_rem_fix;

  // A start is only honoured from IDLE; anything while busy is dropped
  assign w_accept    = (r_state == IDLE) && start;
  // Last permitted WAIT cycle: no div_valid here means the divider is hung
  assign w_wdog_done = (r_wdog == WDW'(WDOG_LIMIT - 1));
  // Quotient sign is the XOR of operand signs; remainder follows the dividend
  assign w_quo_neg   = r_a_sign ^ r_m_sign;

  div_sign_fix #(.W(DIV_W)) u_quo_fix (
    .i_neg (w_quo_neg),
    .i_val (r_quo),
    .o_val (w_quo_fix)
  );

  div_sign_fix #(.W(DIV_W)) u_rem_fix (
    .i_neg (r_a_sign),
    .i_val (r_rem),
    .o_val (w_rem_fix)
  );

  // State register; reset abandons any division in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = m_zero ? WRITE : LAUNCH;
        end
      end
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (div_valid) begin
          w_state_nxt = FIXUP;
        end else if (w_wdog_done) begin
          w_state_nxt = IDLE;
        end
      end
      FIXUP:   w_state_nxt = WRITE;
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    div_start = (r_state == LAUNCH);
    busy      = (r_state != IDLE);
  end

  // Operand signs latched at issue so the CPU may change them afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_sign <= 1'b0;
      r_m_sign <= 1'b0;
    end else if (w_accept && !m_zero) begin
      r_a_sign <= a_sign;
      r_m_sign <= m_sign;
    end
  end

  // Sticky status flags: cleared by the next accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dbz <= 1'b0;
      r_tmo <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= m_zero;
      r_tmo <= 1'b0;
    end else if ((r_state == WAIT) && !div_valid && w_wdog_done) begin
      r_tmo <= 1'b1;
    end
  end

  // Watchdog: restarted on launch, counts every WAIT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
    end else if (r_state == LAUNCH) begin
      r_wdog <= '0;
    end else if (r_state == WAIT) begin
      r_wdog <= r_wdog + WDW'(1);
    end
  end

  // Working quotient/remainder: raw capture, then in-place sign correction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quo <= '0;
      r_rem <= '0;
    end else if (w_accept && m_zero) begin
      r_quo <= DBZ_LO;
      r_rem <= DBZ_HI;
    end else if ((r_state == WAIT) && div_valid) begin
      r_quo <= div_quo;
      r_rem <= div_rem;
    end else if (r_state == FIXUP) begin
      r_quo <= w_quo_fix;
      r_rem <= w_rem_fix;
    end
  end

  // Architectural HI/LO: result commit in WRITE, direct CPU writes only when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == WRITE) begin
      r_hi <= r_rem;
      r_lo <= r_quo;
    end else if (r_state == IDLE) begin
      if (HIin) begin
        r_hi <= bus_in;
      end
      if (LOin) begin
        r_lo <= bus_in;
      end
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign dbz     = r_dbz;
  assign tmo     = r_tmo;
  // Read mux toward the register bus; HI wins when both selects are high
  assign bus_out = HIout ? r_hi : (LOout ? r_lo : '0);

endmodule
